// File: rtl/operand_stack_pkg.sv
// Shared types for the operand/frame stack: opcodes, result codes, FSM states.
// Status needs nine codes, so it is four bits wide.
package operand_stack_pkg;

  typedef enum logic [2:0] {
    NOP, PUSH, POP, REPLACE, FRAME_ENTER, FRAME_LEAVE, GET, SET
  } op_t;

  localparam int STATUS_W = 4;

  typedef enum logic [STATUS_W-1:0] {
    OK, EMPTY, FULL, UNDERFLOW, OVERFLOW, BAD_OFFSET, FRAME_OVF, FRAME_UNF, BAD_OP
  } status_t;

  typedef enum logic {IDLE, COPY} fsm_t;

  // Occupancy status reported after a successful op (FULL wins over EMPTY).
  function automatic status_t level_status(input logic at_cap, input logic at_base);
    if (at_cap) return FULL;
    if (at_base) return EMPTY;
    return OK;
  endfunction

endpackage

// File: rtl/operand_frame_stack_frame_base_lifo.sv
// frame_base_lifo: 2**FDEPTH-deep LIFO holding saved frame bases.
// top is the most recently pushed base (0 when empty). Push when full and
// pop when empty are ignored; the caller checks full/empty first.
module frame_base_lifo #(
  parameter int FDEPTH = 4,
  parameter int BW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [BW-1:0] push_data,
  output logic [BW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int ENTRIES = 1 << FDEPTH;
  localparam logic [FDEPTH:0] CAP = (FDEPTH+1)'(ENTRIES);
  localparam logic [FDEPTH:0] ONE = (FDEPTH+1)'(1);

  logic [BW-1:0]   mem [ENTRIES];
  logic [FDEPTH:0] cnt_q;
  logic [FDEPTH:0] top_ptr;

  assign full    = (cnt_q == CAP);
  assign empty   = (cnt_q == '0);
  assign top_ptr = cnt_q - ONE;
  assign top     = empty ? '0 : mem[top_ptr[FDEPTH-1:0]];

  // Entry storage: written at the current fill level on push.
  always_ff @(posedge clk) begin
    if (push && !full && !reset) mem[cnt_q[FDEPTH-1:0]] <= push_data;
  end

  // Fill counter.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (push && !full) cnt_q <= cnt_q + ONE;
    else if (pop && !empty) cnt_q <= cnt_q - ONE;
  end

endmodule

// File: rtl/operand_frame_stack.sv
// operand_frame_stack: LIFO operand stack with TOS_OUTS top-of-stack taps,
// multi-pop and a hardware call-frame stack. FRAME_LEAVE copies the result
// values down to the frame base one entry per cycle in the COPY state.
// Handshake: a request is taken on a clock edge where req_valid && req_ready;
// req_ready is high only in IDLE. resp_valid pulses for one cycle on the edge
// that completes the op (the accepting edge, or the last COPY move).
// Optional feature: define OPERAND_FRAME_STACK_GETSET_EN to implement GET/SET;
// otherwise both return BAD_OP and get_data is tied to 0.
import operand_stack_pkg::*;

module operand_frame_stack #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 7,
  parameter int FDEPTH   = 4,
  parameter int TOS_OUTS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  op_t                       op,
  input  logic [WIDTH-1:0]          data,
  input  logic [DEPTH:0]            count,
  input  logic [DEPTH:0]            offset,
  output logic                      resp_valid,
  output status_t                   status,
  output logic [DEPTH:0]            index,
  output logic [DEPTH:0]            base,
  output logic [TOS_OUTS*WIDTH-1:0] tos,
  output logic [WIDTH-1:0]          get_data,
  output fsm_t                      dbg_state
);

  localparam int ENTRIES = 1 << DEPTH;
  localparam logic [DEPTH:0] CAP = (DEPTH+1)'(ENTRIES);
  localparam logic [DEPTH:0] ONE = (DEPTH+1)'(1);

  logic [WIDTH-1:0] mem [ENTRIES];

  logic [DEPTH:0]   index_q, index_d, base_q, base_d;
  status_t          status_q, status_d;
  logic             resp_q, resp_d;
  logic [WIDTH-1:0] get_q, get_d;
  fsm_t             state_q, state_d;
  logic [DEPTH:0]   src_q, src_d, dst_q, dst_d, left_q, left_d, cnt_q, cnt_d;

  logic             we;
  logic [DEPTH-1:0] waddr;
  logic [WIDTH-1:0] wdata;

  logic             f_push, f_pop, f_full, f_empty;
  logic [DEPTH:0]   f_top;

  logic             accept;
  logic [DEPTH+1:0] diff;
  logic             under;
  logic [DEPTH:0]   idx_m1;
  logic [DEPTH+1:0] tap;

`ifdef OPERAND_FRAME_STACK_GETSET_EN
  logic [DEPTH:0] avail, slot;
  logic           bad_off;
  assign avail   = index_q - base_q;
  assign bad_off = (offset >= avail);
  assign slot    = base_q + offset;
  assign get_data = get_q;
`else
  logic offset_unused;
  assign offset_unused = ^offset;
  assign get_data = '0;
`endif

  assign accept = req_valid && req_ready;
  // index-count evaluated one bit wider so a large count shows up as negative.
  assign diff   = {1'b0, index_q} - {1'b0, count};
  assign under  = diff[DEPTH+1] || (diff[DEPTH:0] < base_q);
  assign idx_m1 = index_q - ONE;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_q;
  assign status     = status_q;
  assign index      = index_q;
  assign base       = base_q;
  assign dbg_state  = state_q;

  frame_base_lifo #(.FDEPTH(FDEPTH), .BW(DEPTH+1)) u_frames (
    .clk       (clk),
    .reset     (reset),
    .push      (f_push),
    .pop       (f_pop),
    .push_data (base_q),
    .top       (f_top),
    .full      (f_full),
    .empty     (f_empty)
  );

  // Next-state, datapath and storage-write decode for IDLE and COPY.
  always_comb begin
    index_d  = index_q;
    base_d   = base_q;
    status_d = status_q;
    resp_d   = 1'b0;
    get_d    = get_q;
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    left_d   = left_q;
    cnt_d    = cnt_q;
    we       = 1'b0;
    waddr    = index_q[DEPTH-1:0];
    wdata    = data;
    f_push   = 1'b0;
    f_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          resp_d   = 1'b1;
          status_d = level_status(index_q == CAP, index_q == base_q);
          case (op)
            NOP: ;
            PUSH: begin
              if (index_q == CAP) status_d = OVERFLOW;
              else begin
                we       = 1'b1;
                waddr    = index_q[DEPTH-1:0];
                index_d  = index_q + ONE;
                status_d = level_status(index_d == CAP, index_d == base_q);
              end
            end
            POP: begin
              if (under) status_d = UNDERFLOW;
              else begin
                index_d  = diff[DEPTH:0];
                status_d = level_status(index_d == CAP, index_d == base_q);
              end
            end
            REPLACE: begin
              if (index_q == base_q) status_d = UNDERFLOW;
              else begin
                we    = 1'b1;
                waddr = idx_m1[DEPTH-1:0];
              end
            end
            FRAME_ENTER: begin
              if (f_full) status_d = FRAME_OVF;
              else if (under) status_d = UNDERFLOW;
              else begin
                f_push   = 1'b1;
                base_d   = diff[DEPTH:0];
                status_d = level_status(index_q == CAP, index_q == base_d);
              end
            end
            FRAME_LEAVE: begin
              if (f_empty) status_d = FRAME_UNF;
              else if (under) status_d = UNDERFLOW;
              else if ((count == '0) || (diff[DEPTH:0] == base_q)) begin
                // Results already sit at the frame base: no copy needed.
                f_pop    = 1'b1;
                index_d  = base_q + count;
                base_d   = f_top;
                status_d = level_status(index_d == CAP, index_d == base_d);
              end else begin
                resp_d   = 1'b0;
                status_d = status_q;
                state_d  = COPY;
                src_d    = diff[DEPTH:0];
                dst_d    = base_q;
                left_d   = count;
                cnt_d    = count;
              end
            end
`ifdef OPERAND_FRAME_STACK_GETSET_EN
            GET: begin
              if (bad_off) status_d = BAD_OFFSET;
              else get_d = mem[slot[DEPTH-1:0]];
            end
            SET: begin
              if (bad_off) status_d = BAD_OFFSET;
              else begin
                we    = 1'b1;
                waddr = slot[DEPTH-1:0];
              end
            end
`else
            GET, SET: status_d = BAD_OP;
`endif
            default: status_d = BAD_OP;
          endcase
        end
      end
      COPY: begin
        // Ascending copy is safe: the source is always at or above the target.
        we     = 1'b1;
        waddr  = dst_q[DEPTH-1:0];
        wdata  = mem[src_q[DEPTH-1:0]];
        src_d  = src_q + ONE;
        dst_d  = dst_q + ONE;
        left_d = left_q - ONE;
        if (left_q == ONE) begin
          f_pop    = 1'b1;
          index_d  = base_q + cnt_q;
          base_d   = f_top;
          state_d  = IDLE;
          resp_d   = 1'b1;
          status_d = level_status(index_d == CAP, index_d == base_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and status registers; reset also aborts any copy in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_q  <= '0;
      base_q   <= '0;
      status_q <= EMPTY;
      resp_q   <= 1'b0;
      get_q    <= '0;
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      left_q   <= '0;
      cnt_q    <= '0;
    end else begin
      index_q  <= index_d;
      base_q   <= base_d;
      status_q <= status_d;
      resp_q   <= resp_d;
      get_q    <= get_d;
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      left_q   <= left_d;
      cnt_q    <= cnt_d;
    end
  end

  // Operand storage write port (one write per cycle).
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wdata;
  end

  // Top-of-stack taps; a tap below the frame base reads as zero.
  always_comb begin
    tos = '0;
    tap = '0;
    for (int k = 0; k < TOS_OUTS; k++) begin
      tap = {1'b0, index_q} - (DEPTH+2)'(k + 1);
      if (!tap[DEPTH+1] && (tap[DEPTH:0] >= base_q))
        tos[k*WIDTH +: WIDTH] = mem[tap[DEPTH-1:0]];
    end
  end

endmodule
